key_number_capture: RTL and testbench

KEY_NUMBER_CAPTURE -- requirements
Module: key_number_capture

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/mul10_add.sv | 16 +
 rtl/key_number_capture.sv | 157 +++++++++++++++
 tb/tb_key_number_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Purpose : shared types and constants for the keypad operand-capture path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLR = 4'hE;   // '*'
    localparam logic [3:0] KEY_ENT = 4'hF;   // '#'

    localparam int BCD_W = 12;
    localparam int BIN_W = 10;
    localparam int CNT_W = 2;
    localparam int NIB_W = 4;

    // Codes 0x0-0x9 are digits; 0xA-0xD are operators handled elsewhere.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/mul10_add.sv
// Purpose : one BCD-to-binary step, result = acc*10 + nibble.
// Latency : combinational.
// Backpressure: none.
// Ports   : acc (BIN_W) running value, nibble (4) next BCD digit, result (BIN_W).
module mul10_add
    import keypad_pkg::*;
(
    input  logic [BIN_W-1:0] acc,
    input  logic [NIB_W-1:0] nibble,
    output logic [BIN_W-1:0] result
);

    // acc*10 as a shift-add; operands never exceed 999 so 10 bits suffice.
    assign result = (acc << 3) + (acc << 1) + BIN_W'(nibble);

endmodule

// File: rtl/key_number_capture.sv
// Purpose : collects up to MAX_DIGITS keypad digits as BCD and converts them to binary on '#'.
// Latency : num_valid rises on the 4th clk edge after the edge that samples '#'.
// Backpressure: result is held in DONE until num_ack or '*'; keys are dropped while busy.
// Ports   : clk, rst (sync, active-low); key_valid/key_code from debouncer; num_ack from consumer;
//           bcd, digit_count, num_bin, num_valid, busy are all registered.
module key_number_capture
    import keypad_pkg::*;
#(
    // Output widths assume 3 digits; larger values would need wider bcd/count.
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             num_ack,
    output logic [BCD_W-1:0] bcd,
    output logic [CNT_W-1:0] digit_count,
    output logic [BIN_W-1:0] num_bin,
    output logic             num_valid,
    output logic             busy
);

    state_t           state_q,     state_d;
    logic [BCD_W-1:0] bcd_q,       bcd_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [BIN_W-1:0] num_bin_q,   num_bin_d;
    logic             num_valid_q, num_valid_d;
    logic             busy_q,      busy_d;
    logic [BIN_W-1:0] acc_q,       acc_d;
    logic [1:0]       step_q,      step_d;

    logic [NIB_W-1:0] nibble;
    logic [BIN_W-1:0] acc_next;

    logic key_dig;
    logic key_clr;
    logic key_ent;
    logic cnt_room;

    assign key_dig  = key_valid && is_digit(key_code);
    assign key_clr  = key_valid && (key_code == KEY_CLR);
    assign key_ent  = key_valid && (key_code == KEY_ENT);
    assign cnt_room = (int'(cnt_q) < MAX_DIGITS);

    // Most significant nibble first; leading nibbles of a short entry are zero.
    always_comb begin
        nibble = '0;
        case (step_q)
            2'd0:    nibble = bcd_q[11:8];
            2'd1:    nibble = bcd_q[7:4];
            2'd2:    nibble = bcd_q[3:0];
            default: nibble = '0;
        endcase
    end

    mul10_add u_mul10_add (
        .acc    (acc_q),
        .nibble (nibble),
        .result (acc_next)
    );

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        num_bin_d   = num_bin_q;
        num_valid_d = num_valid_q;
        busy_d      = busy_q;
        acc_d       = acc_q;
        step_d      = step_q;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (key_clr) begin
                    bcd_d       = '0;
                    cnt_d       = '0;
                    num_bin_d   = '0;
                    num_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (key_dig) begin
                    // A full operand saturates: extra digits leave everything untouched.
                    if (cnt_room) begin
                        bcd_d   = {bcd_q[BCD_W-NIB_W-1:0], key_code};
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_ENTRY;
                    end
                end else if (key_ent && (state_q == ST_ENTRY)) begin
                    // '#' in IDLE has no digits behind it and is dropped.
                    acc_d   = '0;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                // Steps 0..2 fold in one nibble each (busy high for exactly these
                // three cycles); step 3 publishes the finished accumulator.
                if (step_q != 2'd3) begin
                    acc_d  = acc_next;
                    step_d = step_q + 2'd1;
                    busy_d = (step_q != 2'd2);
                end else begin
                    num_bin_d   = acc_q;
                    num_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // Ack takes priority over any key arriving in the same cycle.
                if (num_ack || key_clr) begin
                    bcd_d       = '0;
                    cnt_d       = '0;
                    num_bin_d   = '0;
                    num_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            cnt_q       <= '0;
            num_bin_q   <= '0;
            num_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            step_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            num_bin_q   <= num_bin_d;
            num_valid_q <= num_valid_d;
            busy_q      <= busy_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_count = cnt_q;
    assign num_bin     = num_bin_q;
    assign num_valid   = num_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_key_number_capture.sv
// Purpose : directed bench for key_number_capture with a result scoreboard.
// Latency : checks the 4-edge '#'-to-num_valid latency and 3-cycle busy window.
// Backpressure: exercises hold-until-ack, ack/key collision, and reset mid-flight.
module tb_key_number_capture;

    typedef struct packed {
        logic [11:0] bcd;
        logic [1:0]  cnt;
        logic [9:0]  bin;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        num_ack;
    logic [11:0] bcd;
    logic [1:0]  digit_count;
    logic [9:0]  num_bin;
    logic        num_valid;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic prev_v = 1'b0;

    key_number_capture #(.MAX_DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .num_ack     (num_ack),
        .bcd         (bcd),
        .digit_count (digit_count),
        .num_bin     (num_bin),
        .num_valid   (num_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising num_valid must match the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (num_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", {22'd0, num_bin}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_num_bin", {22'd0, num_bin}, {22'd0, e.bin});
                check("sb_bcd", {20'd0, bcd}, {20'd0, e.bcd});
                check("sb_digit_count", {30'd0, digit_count}, {30'd0, e.cnt});
            end
        end
        prev_v = num_valid;
    end

    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Press '#' then time the conversion; inject=1 pushes a digit and '*' mid-CONVERT.
    task automatic enter_and_time(input int inject);
        int n;
        int b;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hF;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        n = 0;
        b = busy ? 1 : 0;
        while (!num_valid && n < 10) begin
            if (inject == 1 && n == 0) begin
                key_valid = 1'b1; key_code = 4'h7;
            end else if (inject == 1 && n == 1) begin
                key_valid = 1'b1; key_code = 4'hE;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (busy) b++;
        end
        key_valid = 1'b0;
        check("ent_to_valid_edges", n, 4);
        check("busy_cycles", b, 3);
    endtask

    task automatic do_ack();
        @(negedge clk);
        num_ack = 1'b1;
        @(posedge clk);
        #1;
        num_ack = 1'b0;
        check("ack_valid_clr", {31'd0, num_valid}, 0);
        check("ack_bcd_clr", {20'd0, bcd}, 0);
        check("ack_cnt_clr", {30'd0, digit_count}, 0);
        check("ack_bin_clr", {22'd0, num_bin}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcd"}, {20'd0, bcd}, 0);
        check({tag, "_cnt"}, {30'd0, digit_count}, 0);
        check({tag, "_bin"}, {22'd0, num_bin}, 0);
        check({tag, "_valid"}, {31'd0, num_valid}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        num_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // 4,0,7 '#'
        key(4'h4); key(4'h0); key(4'h7);
        check("e407_bcd", {20'd0, bcd}, 32'h407);
        check("e407_cnt", {30'd0, digit_count}, 3);
        sb_q.push_back('{bcd: 12'h407, cnt: 2'd3, bin: 10'd407});
        enter_and_time(0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", {31'd0, num_valid}, 1);
        check("hold_bin", {22'd0, num_bin}, 407);
        do_ack();

        // 9,9,9,5 -> 4th digit dropped
        key(4'h9); key(4'h9); key(4'h9); key(4'h5);
        check("sat_bcd", {20'd0, bcd}, 32'h999);
        check("sat_cnt", {30'd0, digit_count}, 3);
        sb_q.push_back('{bcd: 12'h999, cnt: 2'd3, bin: 10'd999});
        enter_and_time(0);
        do_ack();
        key(4'h2);
        sb_q.push_back('{bcd: 12'h002, cnt: 2'd1, bin: 10'd2});
        enter_and_time(0);
        do_ack();

        // lone '#', operator key, clear
        key(4'hF);
        repeat (6) @(posedge clk);
        #1;
        check("lone_ent_busy", {31'd0, busy}, 0);
        key(4'hB);
        check("op_ignored_cnt", {30'd0, digit_count}, 0);
        key(4'h1); key(4'hE);
        check("clr_cnt", {30'd0, digit_count}, 0);
        key(4'h6);
        check("after_clr_bcd", {20'd0, bcd}, 32'h6);
        sb_q.push_back('{bcd: 12'h006, cnt: 2'd1, bin: 10'd6});
        enter_and_time(0);
        do_ack();

        // keys during CONVERT, then ack + digit together in DONE
        key(4'h8); key(4'h1);
        sb_q.push_back('{bcd: 12'h081, cnt: 2'd2, bin: 10'd81});
        enter_and_time(1);
        @(negedge clk);
        num_ack   = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h3;
        @(posedge clk);
        #1;
        num_ack   = 1'b0;
        key_valid = 1'b0;
        check("ackwin_cnt", {30'd0, digit_count}, 0);
        check("ackwin_bcd", {20'd0, bcd}, 0);
        check("ackwin_valid", {31'd0, num_valid}, 0);
        key(4'hF);   // must be ignored in IDLE, proving the digit was dropped
        repeat (6) @(posedge clk);

        // reset in 2nd CONVERT cycle
        key(4'h1); key(4'h2);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hF;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all_zero("rst_conv");
        repeat (6) @(posedge clk);

        // reset in DONE
        key(4'h3);
        sb_q.push_back('{bcd: 12'h003, cnt: 2'd1, bin: 10'd3});
        enter_and_time(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all_zero("rst_done");

        key(4'h5);
        sb_q.push_back('{bcd: 12'h005, cnt: 2'd1, bin: 10'd5});
        enter_and_time(0);
        do_ack();

        repeat (4) @(posedge clk);
        #2;
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
